// File: rtl/darkpcgen_pkg.sv
// darkpcgen_pkg -- shared core definitions for the program-counter generator.
//   pcgen_state_t : fetch sequencer states (IDLE / REQ / WAIT / HOLD)
//   INST_BYTES    : size of one instruction in bytes (pc step)
//   align_pc()    : clears the low address bits so a target is word aligned
package darkpcgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } pcgen_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~(INST_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/darkpcgen.sv
// darkpcgen -- program-counter generator / single-entry fetch sequencer.
// Issues one fetch at a time to darkfetch, holds the returned instruction
// for decode, and follows control-transfer redirects from execute.
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   res          in   synchronous active-high reset
//   halt         in   blocks issue of a new fetch (sampled only in IDLE)
//   fetch_en     out  one-cycle fetch request to darkfetch
//   fetch_pc     out  fetch address (current pc)
//   fetch_valid  in   one-cycle fetch completion from darkfetch
//   fetch_inst   in   fetched instruction, qualified by fetch_valid
//   redirect     in   one-cycle taken branch/jump pulse
//   redirect_pc  in   redirect target (low two bits ignored)
//   out_valid    out  instruction available to decode
//   out_ready    in   decode accepts the held instruction
//   out_inst     out  held instruction
//   out_pc       out  address of out_inst
module darkpcgen
  import darkpcgen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        halt,
  output logic        fetch_en,
  output logic [31:0] fetch_pc,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  pcgen_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_kill;
  logic [31:0]  r_inst;
  logic [31:0]  r_out_pc;

  pcgen_state_t w_state_nxt;
  logic [31:0]  w_pc_nxt;
  logic         w_kill_nxt;
  logic         w_capture;
  logic [31:0]  w_target;

  assign w_target = align_pc(redirect_pc);

  // State register: reset overrides every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_kill   <= 1'b0;
      r_inst   <= 32'h0;
      r_out_pc <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_capture) begin
        r_inst   <= fetch_inst;
        r_out_pc <= r_pc;
      end
    end
  end

  // Next-state logic. A redirect always wins over the pc+4 step.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (redirect) w_pc_nxt = w_target;
        if (!halt)    w_state_nxt = REQ;
      end
      REQ: begin
        // The request already went out this cycle; if a redirect lands now
        // the returning instruction belongs to the old path and is killed.
        w_state_nxt = WAIT;
        if (redirect) begin
          w_pc_nxt   = w_target;
          w_kill_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (fetch_valid) begin
          w_state_nxt = IDLE;
          w_kill_nxt  = 1'b0;
          if (redirect) begin
            w_pc_nxt = w_target;
          end else if (!r_kill) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (redirect) begin
          // darkfetch cannot abort, so let the fetch finish and drop it.
          w_pc_nxt   = w_target;
          w_kill_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = IDLE;
        end else if (out_ready) begin
          w_pc_nxt    = r_pc + INST_BYTES;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    fetch_en  = (r_state == REQ);
    out_valid = (r_state == HOLD);
    fetch_pc  = r_pc;
    out_inst  = r_inst;
    out_pc    = r_out_pc;
  end

endmodule

// File: tb/tb_darkpcgen.sv
module tb_darkpcgen;

  logic        clk = 1'b0;
  logic        res;
  logic        halt;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;
  int lat      = 2;

  logic [31:0] fq[$];
  logic [63:0] oq[$];

  darkpcgen #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .res         (res),
    .halt        (halt),
    .fetch_en    (fetch_en),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory model: address 0 holds 32'h00000013.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'h0000_0013 ^ {a[23:0], 8'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_f(input logic [31:0] a);
    fq.push_back(a);
  endtask

  task automatic push_o(input logic [31:0] a);
    oq.push_back({a, inst_of(a)});
  endtask

  // Release halt for exactly one IDLE cycle; returns during the REQ cycle.
  task automatic start_fetch();
    halt = 1'b0;
    tick();
    halt = 1'b1;
  endtask

  task automatic wait_idle();
    repeat (8) tick();
  endtask

  // darkfetch model: latches the address at fetch_en, answers lat cycles later.
  initial begin
    logic [31:0] a;
    fetch_valid = 1'b0;
    fetch_inst  = 32'h0;
    forever begin
      @(negedge clk);
      if (fetch_en && !res) begin
        a = fetch_pc;
        repeat (lat) @(posedge clk);
        #1;
        fetch_valid = 1'b1;
        fetch_inst  = inst_of(a);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
        fetch_inst  = 32'h0;
      end
    end
  end

  // Monitor: pops expected fetch addresses and delivered instructions.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!res) begin
      if (fetch_en) begin
        chk1("fetch_en_with_out_valid", out_valid, 1'b0);
        if (fq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch actual_pc=%h expected=none", fetch_pc);
        end else begin
          chk("fetch_pc", fetch_pc, fq.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (oq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual_pc=%h actual_inst=%h expected=none", out_pc, out_inst);
        end else begin
          e = oq.pop_front();
          chk("out_pc", out_pc, e[63:32]);
          chk("out_inst", out_inst, e[31:0]);
        end
      end
      if (prev_stall && out_valid) begin
        chk("hold_pc_stable", out_pc, prev_pc);
        chk("hold_inst_stable", out_inst, prev_inst);
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      prev_pc    = out_pc;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1; halt = 1'b0; out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0700;   // reset must override this
    repeat (3) tick();
    chk1("rst_fetch_en", fetch_en, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);

    // First fetch after reset, second cycle after deassert.
    push_f(32'h0); push_o(32'h0);
    res = 1'b0; redirect = 1'b0;
    chk1("first_cycle_no_fetch", fetch_en, 1'b0);
    tick();
    chk1("second_cycle_fetch", fetch_en, 1'b1);
    halt = 1'b1;
    wait_idle();
    chk("next_pc_after_first", fetch_pc, 32'h4);

    push_f(32'h4); push_o(32'h4);
    start_fetch();
    wait_idle();

    // Decode stalls for five cycles.
    push_f(32'h8); push_o(32'h8);
    out_ready = 1'b0;
    start_fetch();
    repeat (3) tick();
    repeat (5) begin
      chk1("stall_out_valid", out_valid, 1'b1);
      chk1("stall_no_fetch", fetch_en, 1'b0);
      chk("stall_pc_not_stepped", fetch_pc, 32'h8);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    chk("pc_after_stall_transfer", fetch_pc, 32'hC);

    // Redirect while waiting: returned instruction dropped.
    push_f(32'hC);
    lat = 4;
    start_fetch();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    wait_idle();
    lat = 2;
    chk("pc_after_wait_redirect", fetch_pc, 32'h100);
    push_f(32'h100); push_o(32'h100);
    start_fetch();
    wait_idle();

    // Redirect in the same cycle as fetch_valid.
    push_f(32'h104);
    start_fetch();
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    wait_idle();
    chk("pc_after_coincident_redirect", fetch_pc, 32'h200);
    push_f(32'h200); push_o(32'h200);
    start_fetch();
    wait_idle();

    // Wrap from the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("pc_idle_redirect_aligned", fetch_pc, 32'hFFFF_FFFC);
    push_f(32'hFFFF_FFFC); push_o(32'hFFFF_FFFC);
    start_fetch();
    wait_idle();
    chk("pc_wrap", fetch_pc, 32'h0);
    push_f(32'h0); push_o(32'h0);
    start_fetch();
    wait_idle();

    // halt raised during WAIT does not cancel delivery.
    push_f(32'h4); push_o(32'h4);
    halt = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    wait_idle();
    repeat (4) begin
      chk1("halted_no_fetch", fetch_en, 1'b0);
      tick();
    end
    push_f(32'h8); push_o(32'h8);
    halt = 1'b0;
    tick();
    chk1("fetch_after_unhalt", fetch_en, 1'b1);
    halt = 1'b1;
    wait_idle();

    // Redirect in HOLD without transfer drops the held instruction.
    push_f(32'hC);
    out_ready = 1'b0;
    start_fetch();
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    chk1("hold_redirect_drops", out_valid, 1'b0);
    wait_idle();
    chk("pc_after_hold_redirect", fetch_pc, 32'h300);
    push_f(32'h300); push_o(32'h300);
    start_fetch();
    wait_idle();

    // Redirect in REQ kills the fetch just issued.
    push_f(32'h304);
    start_fetch();
    redirect = 1'b1; redirect_pc = 32'h0000_0402;
    tick();
    redirect = 1'b0;
    wait_idle();
    chk("pc_after_req_redirect", fetch_pc, 32'h400);
    push_f(32'h400); push_o(32'h400);
    start_fetch();
    wait_idle();

    // Reset while a redirect is presented from IDLE.
    res = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0500;
    tick();
    res = 1'b0; redirect = 1'b0;
    chk("reset_overrides_redirect", fetch_pc, 32'h0);
    chk("reset_clears_out_pc", out_pc, 32'h0);
    repeat (3) tick();

    chk("fetch_queue_drained", fq.size(), 32'h0);
    chk("out_queue_drained", oq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
